// File: rtl/laser_beam_ctrl.sv
// Per-beam LIT/DECAY/IDLE display controller for the seven laser-harp strings.
// Optional feature macro: LASER_DECAY_EN enables the blinking DECAY state and per-beam counters.
module laser_beam_ctrl #(
  parameter int BEAM_X0     = 40,
  parameter int BEAM_PITCH  = 80,
  parameter int BEAM_W      = 8,
  parameter int BEAM_Y0     = 32,
  parameter int BEAM_Y1     = 448,
  parameter int HOLD_FRAMES = 6
) (
  input  logic       Clk,
  input  logic       Reset,
  input  logic       frame_start,
  input  logic [6:0] beam_hit,
  input  logic [9:0] DrawX,
  input  logic [9:0] DrawY,
  output logic [2:0] palette_index,
  output logic [6:0] beam_visible
);

`ifdef LASER_DECAY_EN
  typedef enum logic [1:0] {S_IDLE, S_LIT, S_DECAY} beam_state_e;
  logic [7:0] cnt_q [7];
  logic [7:0] cnt_d [7];
`else
  typedef enum logic {S_IDLE, S_LIT} beam_state_e;
  logic unused_hold;
  assign unused_hold = (HOLD_FRAMES != 0);
`endif

  beam_state_e state_q [7];
  beam_state_e state_d [7];
  logic [6:0]  vis_q, vis_d;
  logic [2:0]  pal_q, pal_d;
  logic [10:0] x11, y11, col_lo;
  logic        y_in;

  // Beam state machines advance only on frame_start; visibility follows the post-transition state.
  always_comb begin
    vis_d = vis_q;
    for (int unsigned i = 0; i < 7; i++) begin
      state_d[i] = state_q[i];
`ifdef LASER_DECAY_EN
      cnt_d[i] = cnt_q[i];
`endif
      if (frame_start) begin
        if (beam_hit[i]) begin
          state_d[i] = S_LIT;
`ifdef LASER_DECAY_EN
          cnt_d[i] = '0;
`endif
        end else if (state_q[i] == S_LIT) begin
`ifdef LASER_DECAY_EN
          if (HOLD_FRAMES == 0) begin
            state_d[i] = S_IDLE;
          end else begin
            state_d[i] = S_DECAY;
            cnt_d[i]   = 8'(HOLD_FRAMES);
          end
        end else if (state_q[i] == S_DECAY) begin
          if (cnt_q[i] == 8'd1) begin
            state_d[i] = S_IDLE;
            cnt_d[i]   = '0;
          end else begin
            cnt_d[i] = cnt_q[i] - 8'd1;
          end
`else
          state_d[i] = S_IDLE;
`endif
        end
        if (state_d[i] == S_LIT) begin
          vis_d[i] = 1'b1;
`ifdef LASER_DECAY_EN
        end else if (state_d[i] == S_DECAY) begin
          vis_d[i] = cnt_d[i][0];
`endif
        end else begin
          vis_d[i] = 1'b0;
        end
      end
    end
  end

  // Pixel ownership test in 11-bit unsigned so column bounds cannot wrap.
  always_comb begin
    x11    = {1'b0, DrawX};
    y11    = {1'b0, DrawY};
    y_in   = (y11 >= 11'(BEAM_Y0)) && (y11 < 11'(BEAM_Y1));
    col_lo = '0;
    pal_d  = '0;
    for (int unsigned i = 0; i < 7; i++) begin
      col_lo = 11'(BEAM_X0 + i * BEAM_PITCH);
      if (y_in && vis_q[i] && (x11 >= col_lo) && (x11 < col_lo + 11'(BEAM_W))) begin
        pal_d = 3'(i + 1);
      end
    end
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      for (int unsigned i = 0; i < 7; i++) begin
        state_q[i] <= S_IDLE;
`ifdef LASER_DECAY_EN
        cnt_q[i] <= '0;
`endif
      end
      vis_q <= '0;
      pal_q <= '0;
    end else begin
      for (int unsigned i = 0; i < 7; i++) begin
        state_q[i] <= state_d[i];
`ifdef LASER_DECAY_EN
        cnt_q[i] <= cnt_d[i];
`endif
      end
      vis_q <= vis_d;
      pal_q <= pal_d;
    end
  end

  assign palette_index = pal_q;
  assign beam_visible  = vis_q;

endmodule

// File: tb/tb_laser_beam_ctrl.sv
// Scoreboard bench for laser_beam_ctrl: reference model tracks frames-since-last-hit per beam.
module tb_laser_beam_ctrl;
  localparam int X0 = 40, PITCH = 80, W = 8, Y0 = 32, Y1 = 448, HOLD = 6;

  logic       Clk = 1'b0;
  logic       Reset, frame_start;
  logic [6:0] beam_hit;
  logic [9:0] DrawX, DrawY;
  logic [2:0] palette_index;
  logic [6:0] beam_visible;

  always #5 Clk = ~Clk;

  laser_beam_ctrl #(
    .BEAM_X0(X0), .BEAM_PITCH(PITCH), .BEAM_W(W),
    .BEAM_Y0(Y0), .BEAM_Y1(Y1), .HOLD_FRAMES(HOLD)
  ) dut (
    .Clk(Clk), .Reset(Reset), .frame_start(frame_start), .beam_hit(beam_hit),
    .DrawX(DrawX), .DrawY(DrawY), .palette_index(palette_index), .beam_visible(beam_visible)
  );

  typedef struct {
    logic [2:0] pal;
    logic [6:0] vis;
    string      tag;
  } exp_t;

  exp_t       sb[$];
  int         vectors = 0;
  int         miscompares = 0;
  bit         ever [7];
  int         since [7];
  logic [6:0] mvis = '0;

  // Visibility as a function of frames elapsed since the beam was last seen broken.
  function automatic logic model_vis(input int i);
    if (!ever[i]) return 1'b0;
    if (since[i] == 0) return 1'b1;
`ifdef LASER_DECAY_EN
    if (since[i] <= HOLD) return ((HOLD - since[i] + 1) % 2) == 1;
`endif
    return 1'b0;
  endfunction

  task automatic step(input logic rst, input logic fs, input logic [6:0] hit,
                      input int x, input int y, input string tag);
    exp_t e;
    logic [2:0] p;
    @(negedge Clk);
    Reset = rst; frame_start = fs; beam_hit = hit;
    DrawX = 10'(x); DrawY = 10'(y);
    p = '0;
    for (int i = 0; i < 7; i++)
      if (x >= X0 + i * PITCH && x < X0 + i * PITCH + W && y >= Y0 && y < Y1 && mvis[i])
        p = 3'(i + 1);
    if (rst) begin
      for (int i = 0; i < 7; i++) begin ever[i] = 0; since[i] = 0; end
      mvis = '0;
      p = '0;
    end else if (fs) begin
      for (int i = 0; i < 7; i++) begin
        if (hit[i]) begin ever[i] = 1; since[i] = 0; end
        else if (since[i] < 1000) since[i]++;
      end
      for (int i = 0; i < 7; i++) mvis[i] = model_vis(i);
    end
    e.pal = p; e.vis = mvis; e.tag = tag;
    sb.push_back(e);
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(posedge Clk);
      #1;
      if (sb.size() > 0) begin
        e = sb.pop_front();
        vectors++;
        if (palette_index !== e.pal) begin
          miscompares++;
          $display("FAIL %s palette_index got %0d expected %0d at %0t", e.tag, palette_index, e.pal, $time);
        end
        vectors++;
        if (beam_visible !== e.vis) begin
          miscompares++;
          $display("FAIL %s beam_visible got %h expected %h at %0t", e.tag, beam_visible, e.vis, $time);
        end
      end
    end
  end

  initial begin : stim
    int x, y;
    logic fs, rst;
    logic [6:0] hit;
    for (int i = 0; i < 7; i++) begin ever[i] = 0; since[i] = 0; end

    repeat (3) step(1, 0, 7'h00, 0, 0, "reset");
    step(0, 1, 7'h00, 0, 0, "idle_frame");
    foreach (sb[k]) ; // no-op keeps ordering explicit
    for (int r = 0; r < 5; r++) begin
      y = (r == 0) ? 31 : (r == 1) ? 32 : (r == 2) ? 100 : (r == 3) ? 447 : 448;
      for (int xx = 0; xx < 640; xx += 7) step(0, 0, 7'h00, xx, y, "sweep_black");
    end

    step(0, 1, 7'b0001000, 0, 0, "fs_beam3");
    step(0, 0, 7'b0001000, 280, 100, "b3_in");
    step(0, 0, 7'b0001000, 288, 100, "b3_x_edge");
    step(0, 0, 7'b0001000, 280, 448, "b3_y_edge");
    step(0, 0, 7'b0001000, 287, 447, "b3_corner");
    step(0, 0, 7'b0001000, 0, 0, "flush");

    step(0, 1, 7'h7F, 0, 0, "fs_all");
    step(0, 0, 7'h7F, 40, 200, "b0_left");
    step(0, 0, 7'h7F, 520, 200, "b6_left");
    step(0, 0, 7'h7F, 39, 200, "b0_miss");
    step(0, 0, 7'h7F, 527, 32, "b6_right");
    step(0, 0, 7'h7F, 0, 0, "flush");

    step(1, 0, 7'h00, 0, 0, "reset2");
    step(0, 1, 7'h01, 0, 0, "decay_hit");
    for (int f = 0; f < 8; f++) begin
      step(0, 1, 7'h00, 40, 100, "decay_frame");
      step(0, 0, 7'h00, 44, 100, "decay_pix");
      step(0, 0, 7'h00, 44, 100, "decay_pix2");
    end
    step(0, 1, 7'h01, 0, 0, "rehit");
    for (int f = 0; f < 4; f++) step(0, 1, 7'h00, 40, 100, "release");
    step(0, 1, 7'h01, 40, 100, "rehit_mid");
    step(0, 0, 7'h00, 40, 100, "rehit_pix");

    step(0, 1, 7'h04, 200, 100, "b2_lit");
    step(0, 0, 7'h00, 200, 100, "b2_toggle_lo");
    step(0, 0, 7'h04, 200, 100, "b2_toggle_hi");
    step(0, 0, 7'h00, 200, 100, "b2_toggle_lo2");
    step(0, 0, 7'h00, 200, 100, "b2_hold");
    step(1, 0, 7'h04, 200, 100, "reset_lit");
    step(0, 0, 7'h04, 200, 100, "post_reset");
    step(1, 1, 7'h7F, 200, 100, "reset_vs_fs");
    step(0, 1, 7'h7F, 200, 100, "first_fs");
    step(0, 1, 7'h00, 200, 100, "b2b_fs1");
    step(0, 1, 7'h00, 200, 100, "b2b_fs2");
    step(0, 0, 7'h00, 200, 100, "b2b_pix");

    for (int n = 0; n < 4000; n++) begin
      rst = ($urandom_range(0, 299) == 0);
      fs  = ($urandom_range(0, 9) == 0);
      hit = 7'($urandom) & 7'($urandom);
      if ($urandom_range(0, 1) == 0) begin
        int b;
        b = $urandom_range(0, 6);
        x = X0 + b * PITCH + $urandom_range(0, W + 1) - 1;
      end else begin
        x = $urandom_range(0, 1023);
      end
      y = ($urandom_range(0, 3) == 0) ? $urandom_range(Y0 - 2, Y0 + 1) :
          ($urandom_range(0, 2) == 0) ? $urandom_range(Y1 - 2, Y1 + 1) : $urandom_range(0, 1023);
      step(rst, fs, hit, x, y, "random");
    end

    step(0, 0, 7'h00, 0, 0, "drain");
    @(posedge Clk);
    #2;
    if (sb.size() != 0) begin
      miscompares++;
      $display("FAIL drain scoreboard left %0d expected 0", sb.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule

// File: doc/laser_beam_ctrl.md
# laser_beam_ctrl

Per-beam display controller for the laser harp's seven strings. Samples the seven beam-break inputs once per frame, runs one LIT/DECAY/IDLE state machine per beam, and outputs a registered 3-bit colour index per pixel for the lasers palette lookup (0 = black, 1..7 = orange, indigo, blue, yellow, red, violet, green). Sits between the sensor-debounce logic and the VGA colour mapper.

## Interface
- BEAM_X0, 40: left x of beam 0 column
- BEAM_PITCH, 80: x spacing between beam columns
- BEAM_W, 8: column width in pixels; must satisfy 1 ≤ BEAM_W ≤ BEAM_PITCH
- BEAM_Y0, 32: first drawn row (inclusive)
- BEAM_Y1, 448: last drawn row (exclusive)
- HOLD_FRAMES, 6: decay length in frames, 0..255
- Clk  in  1  pixel clock; single clock domain
- Reset  in  1  synchronous, active-high
- frame_start  in  1  one-cycle pulse at vblank start
- beam_hit  in  7  level, bit i = beam i broken; already synchronised
- DrawX  in  10  current pixel x
- DrawY  in  10  current pixel y
- palette_index  out  3  registered colour index for the current pixel
- beam_visible  out  7  registered per-beam visible flag for the current frame

## Operation
- Per beam i: state {IDLE, LIT, DECAY}, counter cnt[7:0].
- Transitions are evaluated only on cycles with frame_start=1; state and cnt hold at all other times.
  - Any state, beam_hit[i]=1 → LIT, cnt=0. A hit during DECAY restarts LIT.
  - LIT, hit=0 → DECAY with cnt=HOLD_FRAMES; if HOLD_FRAMES=0 → IDLE.
  - DECAY, hit=0: cnt==1 → IDLE, cnt=0; else cnt=cnt−1.
  - IDLE, hit=0 → IDLE.
- Visibility: LIT → 1; DECAY → cnt[0], giving a blink; IDLE → 0. beam_visible[i] is registered from the post-transition state.
- Pixel hit test: beam i owns a pixel when BEAM_X0+i·BEAM_PITCH ≤ DrawX < BEAM_X0+i·BEAM_PITCH+BEAM_W and BEAM_Y0 ≤ DrawY < BEAM_Y1. All arithmetic is 11-bit unsigned, so there is no wrap. Columns never overlap.
- palette_index = i+1 when the pixel is in beam i's column and beam_visible[i]=1; otherwise 0.
- Reset: all beams IDLE, cnt=0, palette_index=0, beam_visible=0. Reset wins over a coincident frame_start.

## Timing
- palette_index has 1-cycle latency: the value for DrawX/DrawY presented at cycle n is valid at cycle n+1.
- beam_hit is sampled only on the frame_start cycle.
- beam_visible updates on the cycle after frame_start and is constant for the rest of the frame, so the picture never tears.
- A hit change between frame_start pulses has no effect until the next pulse.
- Reset asserted mid-frame forces palette_index=0 from the next cycle. The first post-reset frame_start behaves normally.
- Two frame_start pulses on consecutive cycles give two independent evaluations.

## Configuration
- LASER_DECAY_EN defined: DECAY state and blink behave as above.
- LASER_DECAY_EN undefined:
  - LIT with hit=0 → IDLE directly; HOLD_FRAMES is ignored.
  - The DECAY state and the counters are not synthesised.

## Test plan
- Reset, then sweep a full frame with beam_hit=0 → palette_index=0 everywhere; beam_visible=7'h00.
- beam_hit=7'b0001000, pulse frame_start, then DrawX=280, DrawY=100 → palette_index=4 one cycle later. DrawX=288 → 0. DrawY=448 → 0.
- beam_hit=7'h7F then frame_start → beam_visible=7'h7F.
  - DrawX=40 → 1.
  - DrawX=520 → 7.
  - DrawX=39 → 0.
- With LASER_DECAY_EN and HOLD_FRAMES=6: hit beam 0 for 1 frame, then release. beam_visible[0] over the next 7 frames = 0,1,0,1,0,1 (cnt 6..1), then 0, ending in IDLE. Re-hit at cnt=3 → visible=1, state LIT.
- Without LASER_DECAY_EN: same stimulus → beam_visible[0]=0 on the first frame after release.
- Toggle beam_hit[2] mid-frame without frame_start → beam_visible unchanged. Assert Reset while LIT → palette_index=0 and beam_visible=0 the next cycle.
